// File: rtl/dfd_trace_sink_pkg.sv
// ----------------------------------------------------------------------------
// dfd_trace_sink_pkg
//
// Shared types and constants for the trace sink writer slice.
//   state_t        : sink writer control states
//   DROP_CNT_WIDTH : width of the saturating dropped-line counter
//   drop_cnt_inc() : saturating increment for the dropped-line counter
// ----------------------------------------------------------------------------
package dfd_trace_sink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        STOPPED = 2'd3
    } state_t;

    localparam int DROP_CNT_WIDTH = 16;

    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

    // Counter sticks at all-ones instead of rolling back to zero.
    function automatic logic [DROP_CNT_WIDTH-1:0] drop_cnt_inc(
        input logic [DROP_CNT_WIDTH-1:0] value
    );
        return (value == DROP_CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/tt_dfd_generic_dff.sv
// ----------------------------------------------------------------------------
// tt_dfd_generic_dff
//
// Generic enabled flop bank with asynchronous active-low reset to a
// per-instance reset value. Every state element of the slice is built from it.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   en    : load enable
//   d     : next value
//   q     : registered value
// ----------------------------------------------------------------------------
module tt_dfd_generic_dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tt_dfd_trace_line_fifo.sv
// ----------------------------------------------------------------------------
// tt_dfd_trace_line_fifo
//
// Small line FIFO between the trace encoder and the write request port.
// Full/empty come from a registered occupancy count, so a push is never
// accepted on the strength of a same-cycle pop.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : line to store
//   pop        : discard head entry (ignored when empty)
//   flush      : drop all contents, wins over push/pop
//   full       : occupancy == DEPTH
//   empty      : occupancy == 0
//   head       : oldest stored line
// ----------------------------------------------------------------------------
module tt_dfd_trace_line_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    tt_dfd_generic_dff #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_rd_ptr (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .d(rd_ptr_d), .q(rd_ptr_q)
    );

    tt_dfd_generic_dff #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_wr_ptr (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .d(wr_ptr_d), .q(wr_ptr_q)
    );

    tt_dfd_generic_dff #(.WIDTH(CNT_W), .RESET_VALUE('0)) u_count (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .d(count_d), .q(count_q)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        tt_dfd_generic_dff #(.WIDTH(WIDTH), .RESET_VALUE('0)) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (do_push && (wr_ptr_q == PTR_W'(g))),
            .d    (push_data),
            .q    (mem_q[g])
        );
    end

endmodule

// File: rtl/dfd_trace_sink_writer.sv
// ----------------------------------------------------------------------------
// dfd_trace_sink_writer
//
// Buffers packed trace lines and feeds them to the trace AXI write master's
// request port, walking a circular buffer from base to limit (inclusive).
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   trace_en_i            : trace enable level
//   stop_on_wrap_i        : halt after the limit line has been written
//   base_addr_i           : first line address (captured on enable)
//   limit_addr_i          : last line address, inclusive (captured on enable)
//   in_valid_i/in_data_i  : trace line from the encoder
//   in_ready_o            : line accepted when in_valid_i & in_ready_o
//   out_valid_o           : request valid to the master
//   out_addr_o/out_data_o : request address / line
//   out_ready_i           : master ready (registered on the master side)
//   wr_ptr_o              : next line address
//   wrapped_o             : sticky, pointer wrapped since last enable
//   stopped_o             : writer is in STOPPED
//   drop_cnt_o            : lines discarded while STOPPED, saturating
//   busy_o                : writer is not IDLE
// ----------------------------------------------------------------------------
module dfd_trace_sink_writer
    import dfd_trace_sink_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_en_i,
    input  logic                      stop_on_wrap_i,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [AXI_ADDR_WIDTH-1:0] limit_addr_i,
    input  logic                      in_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] in_data_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] out_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] out_data_o,
    input  logic                      out_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] wr_ptr_o,
    output logic                      wrapped_o,
    output logic                      stopped_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                      busy_o
);

    localparam logic [AXI_ADDR_WIDTH-1:0] PTR_STEP = AXI_ADDR_WIDTH'(LINE_BYTES);

    logic [1:0]                state_bits;
    state_t                    state_q;
    state_t                    state_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic [AXI_ADDR_WIDTH-1:0] limit_q;
    logic [AXI_ADDR_WIDTH-1:0] ptr_q;
    logic [AXI_ADDR_WIDTH-1:0] ptr_d;
    logic                      wrapped_q;
    logic                      wrapped_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic [DROP_CNT_WIDTH-1:0] drop_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [AXI_DATA_WIDTH-1:0] fifo_head;

    logic                      start;
    logic                      push;
    logic                      drop;
    logic                      issue;
    logic                      at_limit;
    logic                      wrap_issue;
    logic                      stop_now;

    assign state_q = state_t'(state_bits);

    assign start = (state_q == IDLE) & trace_en_i;

    // Full is registered, so a full FIFO refuses input even while it issues.
    assign in_ready_o = ((state_q == RUN) & ~fifo_full) | (state_q == STOPPED);
    assign push       = in_valid_i & in_ready_o & (state_q == RUN);
    assign drop       = in_valid_i & (state_q == STOPPED);

    // The master counts transaction ids on every valid cycle, so valid must
    // never be raised while it is not ready.
    assign issue      = ((state_q == RUN) | (state_q == DRAIN)) & ~fifo_empty & out_ready_i;
    assign at_limit   = (ptr_q == limit_q);
    assign wrap_issue = issue & at_limit;
    assign stop_now   = wrap_issue & stop_on_wrap_i;

    // Next state. A wrap with stop-on-wrap beats a same-cycle disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trace_en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_now) begin
                    state_d = STOPPED;
                end else if (!trace_en_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (stop_now) begin
                    state_d = STOPPED;
                end else if (fifo_empty && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            STOPPED: begin
                if (!trace_en_i && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer walks base..limit inclusive; the add wraps modulo 2^W, which
    // is what lets a limit below base still be reached.
    always_comb begin
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        drop_d    = drop_q;
        if (start) begin
            ptr_d     = base_addr_i;
            wrapped_d = 1'b0;
            drop_d    = '0;
        end else begin
            if (issue) begin
                ptr_d = at_limit ? base_q : ptr_q + PTR_STEP;
            end
            if (wrap_issue) begin
                wrapped_d = 1'b1;
            end
            if (drop) begin
                drop_d = drop_cnt_inc(drop_q);
            end
        end
    end

    tt_dfd_generic_dff #(.WIDTH(2), .RESET_VALUE(IDLE)) u_state (
        .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(state_d), .q(state_bits)
    );

    tt_dfd_generic_dff #(.WIDTH(AXI_ADDR_WIDTH), .RESET_VALUE('0)) u_base (
        .clk(clk_i), .rst_n(rst_ni), .en(start), .d(base_addr_i), .q(base_q)
    );

    tt_dfd_generic_dff #(.WIDTH(AXI_ADDR_WIDTH), .RESET_VALUE('0)) u_limit (
        .clk(clk_i), .rst_n(rst_ni), .en(start), .d(limit_addr_i), .q(limit_q)
    );

    tt_dfd_generic_dff #(.WIDTH(AXI_ADDR_WIDTH), .RESET_VALUE('0)) u_ptr (
        .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(ptr_d), .q(ptr_q)
    );

    tt_dfd_generic_dff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_wrapped (
        .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(wrapped_d), .q(wrapped_q)
    );

    tt_dfd_generic_dff #(.WIDTH(DROP_CNT_WIDTH), .RESET_VALUE('0)) u_drop (
        .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(drop_d), .q(drop_q)
    );

    // Entering STOPPED throws away whatever is still buffered, including a
    // line accepted on the same edge.
    tt_dfd_trace_line_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(AXI_DATA_WIDTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (push),
        .push_data(in_data_i),
        .pop      (issue),
        .flush    (stop_now),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign out_valid_o = issue;
    assign out_addr_o  = ptr_q;
    assign out_data_o  = fifo_head;
    assign wr_ptr_o    = ptr_q;
    assign wrapped_o   = wrapped_q;
    assign stopped_o   = (state_q == STOPPED);
    assign drop_cnt_o  = drop_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dfd_trace_sink_writer.sv
// ----------------------------------------------------------------------------
// tb_dfd_trace_sink_writer
//
// Scoreboard bench: accepted lines are queued with their acceptance cycle; a
// monitor pops one per request and checks data, address (from a simple
// base/limit walk), status outputs and valid gating. A master model drops
// ready for a random number of cycles after each issued line.
// ----------------------------------------------------------------------------
module tb_dfd_trace_sink_writer;

    logic        clk_i;
    logic        rst_ni;
    logic        trace_en_i;
    logic        stop_on_wrap_i;
    logic [63:0] base_addr_i;
    logic [63:0] limit_addr_i;
    logic        in_valid_i;
    logic [63:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [63:0] out_addr_o;
    logic [63:0] out_data_o;
    logic        out_ready_i;
    logic [63:0] wr_ptr_o;
    logic        wrapped_o;
    logic        stopped_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    typedef struct {
        logic [63:0] data;
        longint      cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    int          start_seq = 0;
    logic [63:0] start_base;
    logic [63:0] start_limit;
    logic [63:0] model_ptr;
    logic [63:0] model_base;
    logic [63:0] model_limit;
    bit          model_wrapped;
    bit          model_stopped;
    int          issue_count = 0;
    int          exp_drop;
    bit          hold_ready;
    bit          always_ready;

    dfd_trace_sink_writer dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .trace_en_i    (trace_en_i),
        .stop_on_wrap_i(stop_on_wrap_i),
        .base_addr_i   (base_addr_i),
        .limit_addr_i  (limit_addr_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .out_valid_o   (out_valid_o),
        .out_addr_o    (out_addr_o),
        .out_data_o    (out_data_o),
        .out_ready_i   (out_ready_i),
        .wr_ptr_o      (wr_ptr_o),
        .wrapped_o     (wrapped_o),
        .stopped_o     (stopped_o),
        .drop_cnt_o    (drop_cnt_o),
        .busy_o        (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Master model: ready drops for 1..3 cycles after each issued line.
    initial begin
        int seen;
        int wait_cnt;
        seen = 0;
        wait_cnt = 0;
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (hold_ready) begin
                out_ready_i = 1'b0;
                wait_cnt = 0;
                seen = issue_count;
            end else if (issue_count != seen) begin
                seen = issue_count;
                wait_cnt = always_ready ? 0 : $urandom_range(3, 1);
                out_ready_i = (wait_cnt == 0);
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                out_ready_i = (wait_cnt == 0);
            end else begin
                out_ready_i = 1'b1;
            end
        end
    end

    // Monitor and reference model.
    initial begin
        int   seen_seq;
        exp_t e;
        seen_seq = 0;
        model_ptr = '0;
        model_base = '0;
        model_limit = '0;
        model_wrapped = 1'b0;
        model_stopped = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) begin
                exp_q.delete();
                model_ptr = '0;
                model_wrapped = 1'b0;
                model_stopped = 1'b0;
                seen_seq = start_seq;
            end else begin
                checkOutput("wr_ptr", wr_ptr_o, model_ptr);
                checkOutput("wrapped", {63'd0, wrapped_o}, {63'd0, model_wrapped});
                checkOutput("stopped", {63'd0, stopped_o}, {63'd0, model_stopped});
                if (model_stopped && !trace_en_i && out_ready_i) begin
                    model_stopped = 1'b0;
                end else if (out_valid_o) begin
                    issue_count++;
                    checkOutput("valid_needs_ready", {63'd0, out_ready_i}, 64'd1);
                    checkOutput("issue_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("no_bypass", {63'd0, e.cyc < cyc}, 64'd1);
                        checkOutput("out_data", out_data_o, e.data);
                        checkOutput("out_addr", out_addr_o, model_ptr);
                        if (model_ptr == model_limit) begin
                            model_ptr = model_base;
                            model_wrapped = 1'b1;
                            if (stop_on_wrap_i) begin
                                model_stopped = 1'b1;
                                exp_q.delete();
                            end
                        end else begin
                            model_ptr = model_ptr + 64'd64;
                        end
                    end
                end
                if (start_seq != seen_seq) begin
                    seen_seq = start_seq;
                    model_base = start_base;
                    model_limit = start_limit;
                    model_ptr = start_base;
                    model_wrapped = 1'b0;
                    model_stopped = 1'b0;
                end
            end
        end
    end

    task automatic startTrace(input logic [63:0] b, input logic [63:0] l, input bit s);
        base_addr_i = b;
        limit_addr_i = l;
        stop_on_wrap_i = s;
        start_base = b;
        start_limit = l;
        exp_drop = 0;
        trace_en_i = 1'b1;
        start_seq++;
        @(posedge clk_i);
        #1;
        checkOutput("start_in_ready", {63'd0, in_ready_o}, 64'd1);
        checkOutput("start_busy", {63'd0, busy_o}, 64'd1);
        checkOutput("start_ptr", wr_ptr_o, b);
        checkOutput("start_wrapped", {63'd0, wrapped_o}, 64'd0);
    endtask

    task automatic applyStimulus(input int n);
        int sent;
        int guard;
        bit acc;
        sent = 0;
        guard = 0;
        in_data_i = {$urandom, $urandom};
        while (sent < n && guard < 1000) begin
            in_valid_i = 1'b1;
            acc = 1'b0;
            @(negedge clk_i);
            if (in_ready_o) begin
                if (model_stopped) begin
                    exp_drop = (exp_drop < 65535) ? exp_drop + 1 : exp_drop;
                end else begin
                    exp_q.push_back('{data: in_data_i, cyc: cyc});
                end
                sent++;
                acc = 1'b1;
            end
            @(posedge clk_i);
            #1;
            if (acc) in_data_i = {$urandom, $urandom};
            guard++;
        end
        in_valid_i = 1'b0;
        checkOutput("lines_accepted", 64'(sent), 64'(n));
    endtask

    task automatic stopTrace();
        trace_en_i = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk_i);
            #1;
            if (!busy_o) break;
        end
        checkOutput("idle_reached", {63'd0, busy_o}, 64'd0);
        checkOutput("all_lines_issued", 64'(exp_q.size()), 64'd0);
        checkOutput("idle_not_stopped", {63'd0, stopped_o}, 64'd0);
        checkOutput("drop_cnt", {48'd0, drop_cnt_o}, 64'(exp_drop));
    endtask

    initial begin
        int acc_cnt;
        bit took;
        logic [63:0] rb;
        logic [63:0] rl;
        rst_ni = 1'b0;
        trace_en_i = 1'b0;
        stop_on_wrap_i = 1'b0;
        base_addr_i = '0;
        limit_addr_i = '0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        start_base = '0;
        start_limit = '0;
        hold_ready = 1'b0;
        always_ready = 1'b1;
        exp_drop = 0;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        checkOutput("rst_out_addr", out_addr_o, 64'd0);
        checkOutput("rst_out_data", out_data_o, 64'd0);
        checkOutput("rst_wr_ptr", wr_ptr_o, 64'd0);
        checkOutput("rst_wrapped", {63'd0, wrapped_o}, 64'd0);
        checkOutput("rst_stopped", {63'd0, stopped_o}, 64'd0);
        checkOutput("rst_drop_cnt", {48'd0, drop_cnt_o}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy_o}, 64'd0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        $display("[TB] circular buffer, three lines, always-ready master");
        startTrace(64'h1000, 64'h10C0, 1'b0);
        applyStimulus(3);
        stopTrace();
        checkOutput("three_lines_no_wrap", {63'd0, wrapped_o}, 64'd0);

        $display("[TB] circular buffer, six lines, wrap expected");
        always_ready = 1'b0;
        startTrace(64'h1000, 64'h10C0, 1'b0);
        applyStimulus(6);
        stopTrace();
        checkOutput("six_lines_wrapped", {63'd0, wrapped_o}, 64'd1);

        $display("[TB] disable with three lines buffered");
        hold_ready = 1'b1;
        startTrace(64'h2000, 64'h2100, 1'b0);
        applyStimulus(3);
        trace_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("drain_in_ready", {63'd0, in_ready_o}, 64'd0);
        hold_ready = 1'b0;
        stopTrace();

        $display("[TB] stop on wrap");
        startTrace(64'h0, 64'h40, 1'b1);
        applyStimulus(5);
        for (int k = 0; k < 300 && !model_stopped; k++) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checkOutput("stopped_after_wrap", {63'd0, stopped_o}, 64'd1);
        checkOutput("stopped_in_ready", {63'd0, in_ready_o}, 64'd1);
        applyStimulus(3);
        checkOutput("drop_cnt_while_stopped", {48'd0, drop_cnt_o}, 64'(exp_drop));
        stopTrace();

        $display("[TB] master stalled for twenty cycles");
        hold_ready = 1'b1;
        startTrace(64'h3000, 64'h30C0, 1'b0);
        acc_cnt = 0;
        in_data_i = {$urandom, $urandom};
        for (int k = 0; k < 20; k++) begin
            in_valid_i = (acc_cnt < 6);
            took = 1'b0;
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back('{data: in_data_i, cyc: cyc});
                acc_cnt++;
                took = 1'b1;
            end
            @(posedge clk_i);
            #1;
            if (took) in_data_i = {$urandom, $urandom};
        end
        in_valid_i = 1'b0;
        checkOutput("stall_accepted", 64'(acc_cnt), 64'd4);
        checkOutput("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
        hold_ready = 1'b0;
        applyStimulus(2);
        stopTrace();

        $display("[TB] randomized base/limit/stop runs");
        for (int r = 0; r < 9; r++) begin
            rb = {$urandom, $urandom} & ~64'h3F;
            case (r % 3)
                0: begin
                    rb = 64'hFFFF_FFFF_FFFF_FF80;
                    rl = 64'h40;
                end
                1: rl = rb;
                default: rl = rb + 64'($urandom_range(5, 0)) * 64'd64;
            endcase
            startTrace(rb, rl, 1'($urandom_range(1, 0)));
            applyStimulus($urandom_range(10, 1));
            stopTrace();
        end

        $display("[TB] reset in RUN with buffered lines");
        hold_ready = 1'b1;
        startTrace(64'h4000, 64'h40C0, 1'b0);
        applyStimulus(2);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("mid_rst_in_ready", {63'd0, in_ready_o}, 64'd0);
        checkOutput("mid_rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        checkOutput("mid_rst_wr_ptr", wr_ptr_o, 64'd0);
        checkOutput("mid_rst_out_data", out_data_o, 64'd0);
        trace_en_i = 1'b0;
        hold_ready = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i);
            #1;
            checkOutput("post_rst_quiet", {63'd0, out_valid_o}, 64'd0);
        end
        startTrace(64'h5000, 64'h5040, 1'b0);
        applyStimulus(3);
        stopTrace();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
